// File: rtl/seg_scan_reader.sv
// Recovers BCD digits from a scanned, active-low 7-segment display bus.
// Each digit position debounces its pattern independently before it is accepted.
module seg_scan_reader #(
  parameter int STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic [3:0] dig_sel,
  input  logic       sample_en,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic [3:0] err,
  output logic       upd,
  output logic       ready,
  output logic       sel_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [3:0] STABLE    = 4'(STABLE_CNT);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic one_cold(input logic [3:0] sel);
    return $countones(~sel) == 1;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  // Returns {legal, bcd}; the blank pattern is legal and maps to 4'hF.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b0000001: return {1'b1, 4'd0};
      7'b1001111: return {1'b1, 4'd1};
      7'b0010010: return {1'b1, 4'd2};
      7'b0000110: return {1'b1, 4'd3};
      7'b1001100: return {1'b1, 4'd4};
      7'b0100100: return {1'b1, 4'd5};
      7'b0100000: return {1'b1, 4'd6};
      7'b0001111: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0000100: return {1'b1, 4'd9};
      SEG_BLANK:  return {1'b1, 4'hF};
      default:    return {1'b0, 4'hF};
    endcase
  endfunction

  // p0: qualified sample on the input bus
  logic       vld_p0;
  logic       rej_p0;
  logic [3:0] acc_p0;
  logic [4:0] dec_p0 [4];

  // p1: registered per-digit tracking state and outputs
  state_t     state_p1 [4];
  logic [6:0] cand_p1  [4];
  logic [3:0] cnt_p1   [4];
  logic [3:0] bcd_p1   [4];
  logic [3:0] err_p1;
  logic [3:0] done_p1;
  logic       upd_p1;
  logic       ready_p1;
  logic       sel_err_p1;

  state_t     state_nxt [4];
  logic [6:0] cand_nxt  [4];
  logic [3:0] cnt_nxt   [4];
  logic [3:0] bcd_nxt   [4];
  logic [3:0] err_nxt;
  logic [3:0] done_nxt;
  logic       upd_nxt;
  logic       ready_nxt;
  logic       sel_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_p1[i] <= ST_IDLE;
        cand_p1[i]  <= SEG_BLANK;
        cnt_p1[i]   <= 4'd0;
        bcd_p1[i]   <= 4'hF;
      end
      err_p1     <= 4'd0;
      done_p1    <= 4'd0;
      upd_p1     <= 1'b0;
      ready_p1   <= 1'b0;
      sel_err_p1 <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_p1[i] <= state_nxt[i];
        cand_p1[i]  <= cand_nxt[i];
        cnt_p1[i]   <= cnt_nxt[i];
        bcd_p1[i]   <= bcd_nxt[i];
      end
      err_p1     <= err_nxt;
      done_p1    <= done_nxt;
      upd_p1     <= upd_nxt;
      ready_p1   <= ready_nxt;
      sel_err_p1 <= sel_err_nxt;
    end
  end

  always_comb begin
    vld_p0 = sample_en && one_cold(dig_sel);
    rej_p0 = sample_en && !one_cold(dig_sel);
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state_p1[i];
      cand_nxt[i]  = cand_p1[i];
      cnt_nxt[i]   = cnt_p1[i];
      acc_p0[i]    = 1'b0;
      if (vld_p0 && !dig_sel[i]) begin
        if (state_p1[i] != ST_IDLE && seg_in == cand_p1[i]) begin
          // A locked digit seeing its own pattern again is a no-op.
          if (state_p1[i] == ST_COUNTING) begin
            cnt_nxt[i] = sat_inc(cnt_p1[i]);
            if (sat_inc(cnt_p1[i]) >= STABLE) begin
              acc_p0[i]    = 1'b1;
              state_nxt[i] = ST_LOCKED;
            end
          end
        end else begin
          cand_nxt[i] = seg_in;
          cnt_nxt[i]  = 4'd1;
          if (STABLE <= 4'd1) begin
            acc_p0[i]    = 1'b1;
            state_nxt[i] = ST_LOCKED;
          end else begin
            state_nxt[i] = ST_COUNTING;
          end
        end
      end
    end
  end

  always_comb begin
    err_nxt     = err_p1;
    done_nxt    = done_p1;
    upd_nxt     = 1'b0;
    sel_err_nxt = rej_p0;
    for (int i = 0; i < 4; i++) begin
      bcd_nxt[i] = bcd_p1[i];
      dec_p0[i]  = decode_seg(seg_in);
      if (acc_p0[i]) begin
        done_nxt[i] = 1'b1;
        if (dec_p0[i][4]) begin
          bcd_nxt[i] = dec_p0[i][3:0];
          err_nxt[i] = 1'b0;
        end else begin
          err_nxt[i] = 1'b1;
        end
      end
      if (bcd_nxt[i] != bcd_p1[i]) upd_nxt = 1'b1;
    end
    if (err_nxt != err_p1) upd_nxt = 1'b1;
    ready_nxt = &done_nxt;
  end

  assign bcd0    = bcd_p1[0];
  assign bcd1    = bcd_p1[1];
  assign bcd2    = bcd_p1[2];
  assign bcd3    = bcd_p1[3];
  assign err     = err_p1;
  assign upd     = upd_p1;
  assign ready   = ready_p1;
  assign sel_err = sel_err_p1;

endmodule

// File: doc/seg_scan_reader.md
SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 Parameter STABLE_CNT, default 3, SHALL set the number of consecutive identical samples needed to accept a digit pattern; legal range 1..15.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state SHALL change only on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 seg_in  input  7  observed segments {a,b,c,d,e,f,g} with a at MSB; active-low (0 = lit).
REQ-006 dig_sel  input  4  scanned digit enables, active-low; bit i low selects digit i.
REQ-007 sample_en  input  1  qualifies seg_in/dig_sel for one cycle.
REQ-008 bcd0..bcd3  output  4 each  accepted digit value per position; 4'hF = blank.
REQ-009 err  output  4  bit i high = last accepted pattern on digit i was not a legal code.
REQ-010 upd  output  1  one-cycle pulse when any bcdN or err bit changes value.
REQ-011 ready  output  1  high once every digit has been accepted at least once.
REQ-012 sel_err  output  1  one-cycle pulse for a rejected sample.

Function
REQ-013 A sample SHALL be taken only on cycles with sample_en=1 and exactly one dig_sel bit low.
REQ-014 For sample_en=1 with dig_sel not one-cold (all high or more than one low), the sample SHALL be discarded, no digit state SHALL change, and sel_err SHALL pulse on the next cycle.
REQ-015 Each digit SHALL hold a 7-bit candidate, a 4-bit saturating match count, and a state in {IDLE, COUNTING, LOCKED}.
REQ-016 IDLE, any sample: candidate<=seg_in, count<=1, go COUNTING; if STABLE_CNT=1, accept immediately and go LOCKED.
REQ-017 COUNTING, seg_in = candidate: count<=count+1; on reaching STABLE_CNT, accept the pattern and go LOCKED.
REQ-018 COUNTING or LOCKED, seg_in differs from candidate: candidate<=seg_in, count<=1, go COUNTING; accepted outputs SHALL hold.
REQ-019 LOCKED, seg_in = candidate: no state change, no re-accept, no upd.
REQ-020 Accept mapping (seg_in -> bcd): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9; err bit cleared.
REQ-021 Accept of 1111111 SHALL set bcd=4'hF and clear the err bit.
REQ-022 Accept of any other pattern SHALL set the err bit and hold the previous bcd value.
REQ-023 Acceptance latency: outputs SHALL reflect the accepted pattern in the cycle after the clock edge that samples the STABLE_CNT-th matching sample.
REQ-024 upd SHALL be high in that same cycle only if at least one of bcdN or err changed.
REQ-025 Samples for different digits SHALL be independent; interleaved scanning SHALL NOT reset other digits' counts.
REQ-026 ready SHALL rise in the cycle the last not-yet-accepted digit first accepts, and stay high until reset.

Reset
REQ-027 rst=1 SHALL force bcd0..bcd3=4'hF, err=0, upd=0, ready=0, sel_err=0, all candidates=1111111, counts=0, states IDLE.
REQ-028 rst SHALL take priority over any simultaneous sample; reset mid-count SHALL discard partial counts.

Verification
REQ-029 STABLE_CNT=3; digit 0 sampled 0010010 three times -> bcd0=2, err[0]=0, upd one pulse one cycle after third sample.
REQ-030 Scan 1001111, 0000110, 0100100, 0000100 on digits 0..3, three rounds interleaved -> bcd=1,3,5,9; ready rises after digit 3's third sample.
REQ-031 Digit 1 locked at 7, then two samples 0000000 followed by 0001111 -> bcd1 stays 7, no upd.
REQ-032 Digit 2 sampled 1110000 three times -> err[2]=1, bcd2 held, upd pulses; then 1111111 x3 -> bcd2=F, err[2]=0.
REQ-033 sample_en=1 with dig_sel=4'b0011 or 4'b1111 -> sel_err pulses, no output change.
REQ-034 rst asserted after two matching samples of 4 on digit 0, then one more sample -> bcd0 stays F, count=1.
